// File: rtl/fetch_ctrl_if.sv
// Instruction-memory bus between the fetch controller (master) and an SRAM-like memory (slave).
// A request is accepted in a cycle where inst_req & inst_addr_ok; inst_req and inst_addr hold until then.
// inst_data_ok marks the single cycle in which inst_rdata carries the word for the accepted address.
interface fetch_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [DATA_W-1:0] inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_addr_ok,
        input  inst_data_ok,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_addr_ok,
        output inst_data_ok,
        output inst_rdata
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage memory sequencer: one outstanding instruction request at a time.
// It buffers a word while decode stalls and squashes returns that a redirect has made stale.
module fetch_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    input  logic [ADDR_W-1:0] next_pc,
    input  logic              stall_d,
    input  logic              flush,
    fetch_ctrl_if.master      bus,
    output logic [DATA_W-1:0] raw_instr,
    output logic              instr_valid,
    output logic              stall_f,
    output logic [1:0]        dbg_state,
    output logic              dbg_drop
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] buf_q,   buf_d;
    logic              drop_q,  drop_d;

    logic              req;
    logic              word_ok;
    logic [DATA_W-1:0] word;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            buf_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            buf_q   <= buf_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        buf_d   = buf_q;
        drop_d  = drop_q;
        req     = 1'b0;
        word_ok = 1'b0;
        word    = '0;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
                addr_d  = flush ? next_pc : pc;
            end

            // The address is never withdrawn once offered; a redirect only marks the reply stale.
            S_REQ: begin
                req = 1'b1;
                if (flush) begin
                    drop_d = 1'b1;
                end
                if (bus.inst_addr_ok) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (bus.inst_data_ok) begin
                    if (drop_q || flush) begin
                        // freg already holds the redirect target unless it arrives this very cycle.
                        state_d = S_REQ;
                        addr_d  = flush ? next_pc : pc;
                        drop_d  = 1'b0;
                    end else if (!stall_d) begin
                        word_ok = 1'b1;
                        word    = bus.inst_rdata;
                        state_d = S_REQ;
                        addr_d  = next_pc;
                    end else begin
                        word_ok = 1'b1;
                        word    = bus.inst_rdata;
                        buf_d   = bus.inst_rdata;
                        state_d = S_HOLD;
                    end
                end else if (flush) begin
                    drop_d = 1'b1;
                end
            end

            S_HOLD: begin
                word_ok = 1'b1;
                word    = buf_q;
                if (flush || !stall_d) begin
                    state_d = S_REQ;
                    addr_d  = next_pc;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // A redirect or a pending squash always wins over a returned word.
    assign instr_valid   = word_ok & ~flush & ~drop_q;
    assign raw_instr     = instr_valid ? word : '0;
    assign stall_f       = ~(instr_valid & ~stall_d);

    assign bus.inst_req  = req;
    assign bus.inst_addr = addr_q;

    assign dbg_state     = state_q;
    assign dbg_drop      = drop_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: models freg and an SRAM-like memory with variable latency.
// Every delivered word must be the memory content at the current freg pc.
module tb_fetch_ctrl;

    localparam int          AW       = 32;
    localparam int          DW       = 32;
    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] pc;
    logic [AW-1:0] next_pc;
    logic          stall_d;
    logic          flush;
    logic [DW-1:0] raw_instr;
    logic          instr_valid;
    logic          stall_f;
    logic [1:0]    dbg_state;
    logic          dbg_drop;

    fetch_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    fetch_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .next_pc     (next_pc),
        .stall_d     (stall_d),
        .flush       (flush),
        .bus         (bus),
        .raw_instr   (raw_instr),
        .instr_valid (instr_valid),
        .stall_f     (stall_f),
        .dbg_state   (dbg_state),
        .dbg_drop    (dbg_drop)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          checks   = 0;
    int          failures = 0;
    logic [DW-1:0] exp_q[$];
    logic [31:0] mem_map [logic [31:0]];
    logic        mon_en   = 1'b0;
    int          delivered = 0;

    // ---------------- environment model state ----------------
    logic        rst_pend, load_pend;
    logic [31:0] load_pc;
    logic        pend, req_seen, wait_prev;
    logic [31:0] pend_addr, wait_addr;
    int          d_cnt, d_lat, w_cnt, w_lat;
    int          a_min, a_max, d_min, d_max;
    int          idle_cycles, accepts;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_map.exists(a)) return mem_map[a];
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver: one clock cycle of freg + memory + control inputs ----------------
    task automatic cycle(input logic rst, input logic fl, input logic st, input logic [31:0] redirect);
        @(posedge clk);
        #1;
        if (rst_pend) begin
            pc        = RESET_PC;
            pend      = 1'b0;
            req_seen  = 1'b0;
            wait_prev = 1'b0;
            exp_q.delete();
            exp_q.push_back(mem_word(pc));
        end else if (load_pend) begin
            pc = load_pc;
            exp_q.delete();
            exp_q.push_back(mem_word(pc));
        end
        reset   = rst;
        flush   = fl;
        stall_d = st;
        next_pc = fl ? redirect : pc + 32'd4;

        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata   = $urandom();
        if (pend) begin
            d_cnt++;
            if (d_cnt >= d_lat) begin
                bus.inst_data_ok = 1'b1;
                bus.inst_rdata   = mem_word(pend_addr);
            end
        end else if (bus.inst_req === 1'b1) begin
            if (!req_seen) begin
                req_seen = 1'b1;
                w_cnt    = 0;
                w_lat    = $urandom_range(a_min, a_max);
            end else begin
                w_cnt++;
            end
            bus.inst_addr_ok = (w_cnt >= w_lat);
        end

        #2;
        if (wait_prev) begin
            check_bit("req_held", bus.inst_req, 1'b1);
            check_word("addr_held", bus.inst_addr, wait_addr);
        end
        wait_prev = (bus.inst_req === 1'b1) && !bus.inst_addr_ok && !rst;
        wait_addr = bus.inst_addr;
        if (bus.inst_req === 1'b1 && bus.inst_addr_ok) begin
            pend        = 1'b1;
            pend_addr   = bus.inst_addr;
            d_cnt       = 0;
            d_lat       = $urandom_range(d_min, d_max);
            req_seen    = 1'b0;
            accepts++;
            idle_cycles = 0;
        end else begin
            idle_cycles++;
        end
        if (bus.inst_data_ok) pend = 1'b0;
        rst_pend  = rst;
        load_pend = fl | (stall_f === 1'b0);
        load_pc   = next_pc;
    endtask

    // ---------------- monitor: compares deliveries against the expected queue ----------------
    always @(negedge clk) begin
        if (mon_en && reset === 1'b0) begin
            if (instr_valid === 1'b1) begin
                check_bit("deliver_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    check_word("raw_instr", raw_instr, exp_q[0]);
                    if (!stall_d) begin
                        void'(exp_q.pop_front());
                        delivered++;
                    end
                end
            end else begin
                check_word("raw_zero", raw_instr, 32'h0);
            end
            if (flush) check_bit("flush_squash", instr_valid, 1'b0);
        end
    end

    task automatic check_reset_outputs(input string tag);
        check_bit({tag, "_req"}, bus.inst_req, 1'b0);
        check_bit({tag, "_valid"}, instr_valid, 1'b0);
        check_word({tag, "_raw"}, raw_instr, 32'h0);
        check_bit({tag, "_stall_f"}, stall_f, 1'b1);
        check_word({tag, "_state"}, {30'b0, dbg_state}, 32'd0);
        check_bit({tag, "_drop"}, dbg_drop, 1'b0);
    endtask

    // ---------------- directed scenarios, then randomized run ----------------
    initial begin
        reset = 1'b1; flush = 1'b0; stall_d = 1'b0;
        pc = RESET_PC; next_pc = RESET_PC;
        bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0; bus.inst_rdata = '0;
        rst_pend = 1'b1; load_pend = 1'b0; load_pc = '0;
        pend = 1'b0; req_seen = 1'b0; wait_prev = 1'b0;
        pend_addr = '0; wait_addr = '0;
        d_cnt = 0; d_lat = 1; w_cnt = 0; w_lat = 0;
        idle_cycles = 0; accepts = 0;
        mem_map[RESET_PC]         = 32'h2408_0001;
        mem_map[RESET_PC + 32'd4] = 32'h8C09_0004;
        a_min = 0; a_max = 0; d_min = 1; d_max = 1;

        repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'h0);
        mon_en = 1'b1;

        // T1: reset state, then first fetch with single-cycle handshakes
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check_reset_outputs("t1_reset");
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check_bit("t1_req", bus.inst_req, 1'b1);
        check_word("t1_addr", bus.inst_addr, 32'hBFC0_0000);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check_bit("t1_valid", instr_valid, 1'b1);
        check_word("t1_raw", raw_instr, 32'h2408_0001);
        check_bit("t1_stall_f", stall_f, 1'b0);

        // T2: decode stalls for three cycles while a word is returned
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check_word("t2_addr", bus.inst_addr, 32'hBFC0_0004);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 32'h0);
            check_bit("t2_hold_valid", instr_valid, 1'b1);
            check_word("t2_hold_raw", raw_instr, 32'h8C09_0004);
            check_bit("t2_hold_stall_f", stall_f, 1'b1);
            check_bit("t2_hold_noreq", bus.inst_req, 1'b0);
        end
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check_bit("t2_release_valid", instr_valid, 1'b1);
        check_bit("t2_release_stall_f", stall_f, 1'b0);
        d_min = 3; d_max = 3;
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check_bit("t2_next_req", bus.inst_req, 1'b1);
        check_word("t2_next_addr", bus.inst_addr, 32'hBFC0_0008);

        // T3: redirect while waiting for data
        cycle(1'b0, 1'b1, 1'b0, 32'hBFC0_0380);
        check_bit("t3_flush_valid", instr_valid, 1'b0);
        d_min = 1; d_max = 1;
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check_bit("t3_data_ok", bus.inst_data_ok, 1'b1);
        check_bit("t3_dropped", instr_valid, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check_word("t3_refetch_addr", bus.inst_addr, 32'hBFC0_0380);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check_bit("t3_refetch_valid", instr_valid, 1'b1);

        // T4: redirect while the address phase is held off for three cycles
        a_min = 3; a_max = 3;
        cycle(1'b0, 1'b1, 1'b0, 32'hBFC0_1000);
        check_word("t4_addr", bus.inst_addr, 32'hBFC0_0384);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 32'h0);
            check_bit("t4_req_kept", bus.inst_req, 1'b1);
            check_word("t4_addr_kept", bus.inst_addr, 32'hBFC0_0384);
        end
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check_bit("t4_addr_ok", bus.inst_addr_ok, 1'b1);
        a_min = 0; a_max = 0;
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check_bit("t4_dropped", instr_valid, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check_word("t4_refetch_addr", bus.inst_addr, 32'hBFC0_1000);

        // T5: redirect in the same cycle as the returned word
        cycle(1'b0, 1'b1, 1'b0, 32'h8000_0000);
        check_bit("t5_data_ok", bus.inst_data_ok, 1'b1);
        check_bit("t5_valid", instr_valid, 1'b0);
        check_bit("t5_stall_f", stall_f, 1'b1);
        d_min = 3; d_max = 3;
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check_word("t5_refetch_addr", bus.inst_addr, 32'h8000_0000);
        check_bit("t5_drop_clear", dbg_drop, 1'b0);

        // T6: reset while waiting for data
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check_word("t6_in_wait", {30'b0, dbg_state}, 32'd2);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check_reset_outputs("t6_reset");

        // Randomized traffic: variable latencies, stalls, redirects, occasional resets
        a_min = 0; a_max = 2; d_min = 1; d_max = 3;
        for (int n = 0; n < 3000; n++) begin
            logic r, f, s;
            logic [31:0] tgt;
            r   = ($urandom_range(0, 999) < 3);
            f   = ($urandom_range(0, 99) < 8);
            s   = ($urandom_range(0, 99) < 30);
            tgt = 32'h8000_0000 + {18'b0, 12'($urandom_range(0, 4095)), 2'b00};
            cycle(r, f, s, tgt);
            if (idle_cycles > 60) begin
                checks++;
                failures++;
                $display("FAIL bus_timeout: got %0d idle cycles expected at most 60", idle_cycles);
                break;
            end
        end
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check_bit("throughput", delivered >= 300, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
